// File: rtl/flog_pkg.sv
// rtl/flog_pkg.sv - shared widths, bias and special-case codes for the bfloat16 log2 front end
package flog_pkg;

  localparam int EXP_WIDTH   = 8;
  localparam int FRACT_WIDTH = 7;
  localparam int BIAS        = 127;

  // Special-case code carried alongside the log result
  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    ZERO   = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } special_e;

endpackage

// File: rtl/f2log_if.sv
// rtl/f2log_if.sv - operand/result handshake bundle between a producer and f2log
interface f2log_if;
  import flog_pkg::*;

  logic                   valid_f2i_i;
  logic [15:0]            data_i;
  logic                   ready_f2i_o;
  logic [EXP_WIDTH-1:0]   integer_o;
  logic [FRACT_WIDTH-1:0] log_f_o;
  logic [1:0]             special_o;
  logic                   valid_f2i_o;

  // f2log side
  modport slave (
    input  valid_f2i_i, data_i,
    output ready_f2i_o, integer_o, log_f_o, special_o, valid_f2i_o
  );

  // Operand producer / result consumer side
  modport master (
    output valid_f2i_i, data_i,
    input  ready_f2i_o, integer_o, log_f_o, special_o, valid_f2i_o
  );

endinterface

// File: rtl/log2_sq.sv
// rtl/log2_sq.sv - 16x16 unsigned combinational squarer for the log2 bit iteration
module log2_sq (
  input  logic [15:0] i_a,
  output logic [31:0] o_sq
);

  assign o_sq = 32'(i_a) * 32'(i_a);

endmodule

// File: rtl/f2log.sv
// rtl/f2log.sv - bfloat16 to log2 converter: integer part from exponent, fraction by iterative squaring
module f2log
  import flog_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  f2log_if.slave bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CLASSIFY = 2'd1;
  localparam logic [1:0] S_ITER     = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam logic [EXP_WIDTH-1:0] BIAS_W   = EXP_WIDTH'(BIAS);
  localparam logic [2:0]           LAST_BIT = 3'(FRACT_WIDTH - 1);

  logic [1:0]             r_state;
  logic [15:0]            r_data;
  logic [15:0]            r_y;
  logic [2:0]             r_cnt;
  logic [EXP_WIDTH-1:0]   r_int;
  logic [FRACT_WIDTH-1:0] r_log_f;
  special_e               r_special;
  logic                   r_valid;

  logic                   w_sign;
  logic [7:0]             w_exp;
  logic [6:0]             w_mant;
  logic [31:0]            w_sq;
  logic                   w_bit;
  logic [15:0]            w_y_next;
  logic                   w_sq_unused;
  logic                   w_is_special;
  special_e               w_special_code;

  assign w_sign = r_data[15];
  assign w_exp  = r_data[14:7];
  assign w_mant = r_data[6:0];

  log2_sq u_sq (
    .i_a  (r_y),
    .o_sq (w_sq)
  );

  // y*y >= 2 means the next fraction bit is 1; renormalise y back into [1,2)
  assign w_bit       = w_sq[31];
  assign w_y_next    = w_bit ? w_sq[31:16] : w_sq[30:15];
  assign w_sq_unused = ^w_sq[14:0];

  // Classify the captured operand; zero/subnormal wins over sign so -0 is ZERO
  always_comb begin
    w_is_special   = 1'b1;
    w_special_code = NORMAL;
    if (w_exp == 8'd0) begin
      w_special_code = ZERO;
    end else if (w_sign) begin
      w_special_code = NAN;
    end else if (w_exp == 8'hFF) begin
      w_special_code = (w_mant == 7'd0) ? INF : NAN;
    end else begin
      w_is_special = 1'b0;
    end
  end

  // Control FSM and result registers; valid pulses for the single cycle after DONE
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_data    <= '0;
      r_y       <= '0;
      r_cnt     <= '0;
      r_int     <= '0;
      r_log_f   <= '0;
      r_special <= NORMAL;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.valid_f2i_i) begin
            r_data  <= bus.data_i;
            r_state <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          r_log_f <= '0;
          if (w_is_special) begin
            r_int     <= '0;
            r_special <= w_special_code;
            r_state   <= S_DONE;
          end else begin
            r_int     <= w_exp - BIAS_W;
            r_y       <= {1'b1, w_mant, 8'b0};
            r_cnt     <= '0;
            r_special <= NORMAL;
            r_state   <= S_ITER;
          end
        end
        S_ITER: begin
          r_y     <= w_y_next;
          r_log_f <= {r_log_f[FRACT_WIDTH-2:0], w_bit};
          r_cnt   <= r_cnt + 3'd1;
          if (r_cnt == LAST_BIT) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_valid <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_f2i_o = (r_state == S_IDLE);
  assign bus.integer_o   = r_int;
  assign bus.log_f_o     = r_log_f;
  assign bus.special_o   = r_special;
  assign bus.valid_f2i_o = r_valid;

endmodule

// File: tb/tb_f2log.sv
// tb/tb_f2log.sv - directed self-checking bench for f2log
module tb_f2log;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  f2log_if bus ();

  f2log dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand in IDLE and check latency, result and single-cycle pulse
  task automatic run_op(input string tag, input logic [15:0] d, input logic [7:0] ei,
                        input logic [6:0] el, input logic [1:0] es, input int elat);
    int  n;
    bit  seen;
    bus.valid_f2i_i = 1'b1;
    bus.data_i      = d;
    tick();
    bus.valid_f2i_i = 1'b0;
    check({tag, "_busy"}, 32'(bus.ready_f2i_o), 32'd0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (bus.valid_f2i_o) seen = 1'b1;
    end
    check({tag, "_lat"}, 32'(n), 32'(elat));
    check({tag, "_int"}, 32'(bus.integer_o), 32'(ei));
    check({tag, "_logf"}, 32'(bus.log_f_o), 32'(el));
    check({tag, "_sp"}, 32'(bus.special_o), 32'(es));
    tick();
    check({tag, "_pulse"}, 32'(bus.valid_f2i_o), 32'd0);
    check({tag, "_hold"}, {bus.integer_o, bus.log_f_o, bus.special_o}, {15'd0, ei, el, es});
  endtask

  initial begin
    int  n;
    bit  seen;
    int  pulses;
    n_tests = 0;
    n_fail  = 0;
    rst             = 1'b0;
    bus.valid_f2i_i = 1'b0;
    bus.data_i      = 16'h0000;

    tick();
    tick();
    check("rst_ready", 32'(bus.ready_f2i_o), 32'd1);
    check("rst_valid", 32'(bus.valid_f2i_o), 32'd0);
    check("rst_outs", {bus.integer_o, bus.log_f_o, bus.special_o}, 32'd0);
    rst = 1'b1;
    tick();

    run_op("one",      16'h3F80, 8'h00, 7'd0,   2'd0, 9);
    run_op("p1p5",     16'h3FC0, 8'h00, 7'd74,  2'd0, 9);
    run_op("p0p75",    16'h3F40, 8'hFF, 7'd74,  2'd0, 9);
    run_op("two",      16'h4000, 8'h01, 7'd0,   2'd0, 9);
    run_op("maxfin",   16'h7F7F, 8'h7F, 7'd127, 2'd0, 9);
    run_op("pzero",    16'h0000, 8'h00, 7'd0,   2'd1, 2);
    run_op("nzero",    16'h8000, 8'h00, 7'd0,   2'd1, 2);
    run_op("subn",     16'h0005, 8'h00, 7'd0,   2'd1, 2);
    run_op("inf",      16'h7F80, 8'h00, 7'd0,   2'd2, 2);
    run_op("neg",      16'hBF80, 8'h00, 7'd0,   2'd3, 2);
    run_op("nan",      16'h7FC1, 8'h00, 7'd0,   2'd3, 2);
    run_op("p1p5b",    16'h3FC0, 8'h00, 7'd74,  2'd0, 9);

    // New operand offered during ITER must be dropped
    bus.valid_f2i_i = 1'b1;
    bus.data_i      = 16'h3FC0;
    tick();
    bus.valid_f2i_i = 1'b0;
    n = 0;
    tick(); n++;
    tick(); n++;
    bus.valid_f2i_i = 1'b1;
    bus.data_i      = 16'h4000;
    tick(); n++;
    tick(); n++;
    bus.valid_f2i_i = 1'b0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (bus.valid_f2i_o) seen = 1'b1;
    end
    check("ign_lat", 32'(n), 32'd9);
    check("ign_int", 32'(bus.integer_o), 32'h00);
    check("ign_logf", 32'(bus.log_f_o), 32'd74);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.valid_f2i_o) pulses++;
    end
    check("ign_noqueue", 32'(pulses), 32'd0);

    // Back-to-back: held valid is taken in the IDLE cycle of the result pulse
    bus.valid_f2i_i = 1'b1;
    bus.data_i      = 16'h4000;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (bus.valid_f2i_o) seen = 1'b1;
    end
    check("b2b_first_int", 32'(bus.integer_o), 32'h01);
    check("b2b_ready", 32'(bus.ready_f2i_o), 32'd1);
    bus.data_i = 16'h3F40;
    tick();
    bus.valid_f2i_i = 1'b0;
    check("b2b_accept", 32'(bus.ready_f2i_o), 32'd0);
    n    = 1;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (bus.valid_f2i_o) seen = 1'b1;
    end
    check("b2b_lat", 32'(n), 32'd10);
    check("b2b_int", 32'(bus.integer_o), 32'hFF);
    check("b2b_logf", 32'(bus.log_f_o), 32'd74);
    tick();

    // Reset during the 4th ITER cycle aborts with no pulse
    bus.valid_f2i_i = 1'b1;
    bus.data_i      = 16'h4000;
    tick();
    bus.valid_f2i_i = 1'b0;
    tick();
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("abort_ready", 32'(bus.ready_f2i_o), 32'd1);
    check("abort_valid", 32'(bus.valid_f2i_o), 32'd0);
    check("abort_outs", {bus.integer_o, bus.log_f_o, bus.special_o}, 32'd0);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.valid_f2i_o) pulses++;
    end
    check("abort_nopulse", 32'(pulses), 32'd0);

    run_op("after_rst", 16'h3FC0, 8'h00, 7'd74, 2'd0, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/f2log.md
F2LOG -- requirements
Module: f2log

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-low reset, sampled on the clk rising edge.
REQ-003 SHALL have port valid_f2i_i, input, 1, data_i qualifier; accepted only while ready_f2i_o=1.
REQ-004 SHALL have port data_i, input, 16, bfloat16 operand: sign [15], exponent [14:7], mantissa [6:0].
REQ-005 SHALL have port ready_f2i_o, output, 1, high only in IDLE.
REQ-006 SHALL have port integer_o, output, EXP_WIDTH, two's-complement integer part of log2(x), equal to exponent-BIAS; feeds i2f integer_i.
REQ-007 SHALL have port log_f_o, output, FRACT_WIDTH, unsigned truncated fractional part of log2(1.mantissa); feeds i2f log_f_i.
REQ-008 SHALL have port special_o, output, 2, special-case code: NORMAL=0, ZERO=1 (log=-inf), INF=2, NAN=3.
REQ-009 SHALL have port valid_f2i_o, output, 1, one-cycle pulse qualifying integer_o, log_f_o and special_o; feeds i2f valid_i2f_i.

Function
REQ-010 SHALL implement FSM states IDLE, CLASSIFY, ITER, DONE.
REQ-011 IDLE: when valid_f2i_i=1, SHALL capture data_i and go to CLASSIFY; otherwise stay in IDLE.
REQ-012 CLASSIFY: exponent=0 (zero or subnormal, either sign) SHALL yield ZERO; sign=1 with exponent nonzero SHALL yield NAN; exponent=255 with mantissa=0 SHALL yield INF; exponent=255 with mantissa nonzero SHALL yield NAN; these cases SHALL go to DONE.
REQ-013 CLASSIFY, all other inputs: SHALL load integer_o register with exponent-BIAS (8-bit wrap, two's complement), load y register (Q1.15, unsigned) with {1, mantissa, 8'b0}, clear the bit counter, and go to ITER.
REQ-014 ITER: each cycle SHALL compute s=y*y (Q2.30); if s[31]=1, SHALL emit fraction bit 1 and set y=s[31:16]; else SHALL emit 0 and set y=s[30:15]. Bits fill log_f MSB first.
REQ-015 ITER SHALL last exactly FRACT_WIDTH (7) cycles, then go to DONE; no rounding, result truncated.
REQ-016 DONE: SHALL assert valid_f2i_o for exactly one cycle and return to IDLE.
REQ-017 Outputs SHALL be registered and held stable from valid_f2i_o until the next acceptance.
REQ-018 Special cases SHALL force integer_o=0 and log_f_o=0.
REQ-019 Latency: with acceptance at edge N, valid_f2i_o SHALL be high during the cycle after edge N+9 (normal) or edge N+2 (special).
REQ-020 valid_f2i_i while ready_f2i_o=0 SHALL be ignored and not queued.
REQ-021 Back-to-back: valid_f2i_i held high SHALL be accepted in the IDLE cycle following DONE.

Reset
REQ-022 rst=0 at a clk edge SHALL force IDLE, ready_f2i_o=1, valid_f2i_o=0, integer_o=0, log_f_o=0, special_o=NORMAL, y=0, counter=0.
REQ-023 Reset in any state, including mid-ITER, SHALL abort the operation with no valid_f2i_o pulse.

Structure
REQ-024 EXP_WIDTH=8, FRACT_WIDTH=7, BIAS=127 and the special-code enum SHALL come from flog_pkg; the FSM state enum SHALL be local.
REQ-025 The 16x16 unsigned squarer SHALL be a separate combinational sub-module, log2_sq.

Verification
REQ-026 data_i=0x3F80 (1.0) -> integer_o=0x00, log_f_o=0x00, special_o=0, valid after 9 cycles.
REQ-027 data_i=0x3FC0 (1.5) -> integer_o=0x00, log_f_o=7'b1001010 (74); data_i=0x3F40 (0.75) -> integer_o=0xFF, log_f_o=74.
REQ-028 data_i=0x4000 (2.0) -> integer_o=0x01, log_f_o=0; 0x7F7F -> integer_o=0x7F, log_f_o=7'b1111111.
REQ-029 0x0000 and 0x8000 -> ZERO; 0x7F80 -> INF; 0xBF80 and 0x7FC1 -> NAN; each with valid after 2 cycles and integer_o=log_f_o=0.
REQ-030 valid_f2i_i pulsed during ITER -> ignored, first result unchanged; rst=0 at the 4th ITER cycle -> no valid_f2i_o, IDLE and all outputs 0 on the next edge.
